// File: rtl/add_arb_pkg.sv
// Shared types, defaults and round-robin pick helper for add_share_arbiter.
package add_arb_pkg;

    localparam int unsigned ADD_ARB_NREQ     = 4;
    localparam int unsigned ADD_ARB_DW       = 4;
    localparam int unsigned ADD_ARB_MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // First set bit of valid searching upward from last+1, wrapping at nreq.
    // Returns last unchanged when nothing is valid; caller qualifies with |valid.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] last,
                                           input int unsigned nreq);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= ADD_ARB_MAX_NREQ; k++) begin
            idx = (32'(last) + k) % nreq;
            if (!found && (k <= nreq) && valid[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/add_core.sv
// Registered adder: sum is a+b with the carry kept in the extra MSB.
module add_core
    import add_arb_pkg::*;
#(
    parameter int unsigned DW = ADD_ARB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW:0]   sum
);

    logic [DW:0] sum_d;
    logic [DW:0] sum_q;

    // Zero-extend both operands so the carry lands in the MSB.
    always_comb begin
        sum_d = (DW+1)'(a) + (DW+1)'(b);
    end

    // Result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one registered adder between NREQ requesters.
// One operation in flight at a time: IDLE (grant) -> CALC (add) -> RESP (hold until taken).
// Optional per-requester grant counters are built when ADD_ARB_STATS_EN is defined.
module add_share_arbiter
    import add_arb_pkg::*;
#(
    parameter  int unsigned NREQ = ADD_ARB_NREQ,
    parameter  int unsigned DW   = ADD_ARB_DW,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [DW:0]       rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready
`ifdef ADD_ARB_STATS_EN
    ,
    output logic [NREQ*8-1:0] grant_cnt
`endif
);

    state_t         state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [IDW-1:0] grant;
    logic           any_valid;
    logic [DW:0]    core_sum;

    // Candidate grant for this cycle, starting after the previous winner.
    always_comb begin
        any_valid = |req_valid;
        grant     = IDW'(rr_pick(8'(req_valid), 3'(last_grant_q), NREQ));
    end

    // Next-state, operand capture and accept strobe.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gid_d        = gid_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        req_ready    = '0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready[grant] = 1'b1;
                    a_d              = req_a[grant*DW +: DW];
                    b_d              = req_b[grant*DW +: DW];
                    gid_d            = grant;
                    last_grant_d     = grant;
                    state_d          = CALC;
                end
            end
            CALC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = gid_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            gid_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    // Operands only change on a grant, so the sum holds until the next op completes.
    add_core #(
        .DW (DW)
    ) u_add_core (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_q),
        .b     (b_q),
        .sum   (core_sum)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = core_sum;
    assign rsp_id    = rsp_id_q;

`ifdef ADD_ARB_STATS_EN
    logic [7:0] cnt_q [NREQ];
    logic [7:0] cnt_d [NREQ];

    // One wrapping 8-bit counter per requester, bumped on each accept strobe.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            cnt_d[i] = cnt_q[i] + 8'(req_ready[i]);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < int'(NREQ); g++) begin : g_cnt_out
        assign grant_cnt[g*8 +: 8] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: directed cases plus randomized traffic against a
// transaction-level reference model (pending ops, free/busy flags, expected hold values).
module tb_add_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [DW:0]          rsp_sum;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_ready;
`ifdef ADD_ARB_STATS_EN
    logic [NREQ*8-1:0]    grant_cnt;
`endif

    add_share_arbiter #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
`ifdef ADD_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side pending operations.
    bit pv [NREQ];
    int pa [NREQ];
    int pb [NREQ];

    // Reference model.
    bit m_calc;
    bit m_out;
    int m_last;
    int p_sum, p_id;
    int m_sum, m_id;
    int m_cnt [NREQ];
    int exp_grant;
    int cyc;

    // Observed accepted responses.
    int got_sum [$];
    int got_id  [$];
    int got_cyc [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pv[i];
            req_a[i*DW +: DW]  = DW'(pa[i]);
            req_b[i*DW +: DW]  = DW'(pb[i]);
        end
    endtask

    // Arbiter rule: free only with nothing in flight; pick first valid after last winner.
    function automatic int ref_grant();
        if (m_calc || m_out) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (pv[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_calc = 0; m_out = 0; m_last = NREQ - 1;
        p_sum = 0; p_id = 0; m_sum = 0; m_id = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic clear_q();
        got_sum.delete(); got_id.delete(); got_cyc.delete();
    endtask

    // One clock: drive, check against model, advance model at the edge.
    task automatic cycle();
        logic [NREQ-1:0] exp_rdy;
        drive();
        #1;
        exp_grant = ref_grant();
        exp_rdy   = (exp_grant >= 0) ? NREQ'(1 << exp_grant) : '0;
        check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_val("rsp_valid", 32'(rsp_valid), 32'(m_out));
        check_val("rsp_sum", 32'(rsp_sum), m_sum);
        check_val("rsp_id", 32'(rsp_id), m_id);
`ifdef ADD_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            check_val("grant_cnt", 32'(grant_cnt[i*8 +: 8]), m_cnt[i] & 255);
`endif
        if (rsp_valid === 1'b1 && rsp_ready) begin
            got_sum.push_back(int'(rsp_sum));
            got_id.push_back(int'(rsp_id));
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        if (m_out) begin
            if (rsp_ready) m_out = 0;
        end else if (m_calc) begin
            m_calc = 0; m_out = 1; m_sum = p_sum; m_id = p_id;
        end else if (exp_grant >= 0) begin
            p_sum = pa[exp_grant] + pb[exp_grant];
            p_id  = exp_grant;
            m_last = exp_grant;
            m_calc = 1;
            m_cnt[exp_grant]++;
            pv[exp_grant] = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin pv[i] = 0; pa[i] = 0; pb[i] = 0; end
        drive();
        #2;
        check_val("rst_rsp_valid", 32'(rsp_valid), 0);
        check_val("rst_rsp_sum", 32'(rsp_sum), 0);
        check_val("rst_rsp_id", 32'(rsp_id), 0);
        check_val("rst_req_ready", 32'(req_ready), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
    endtask

    initial begin
        rsp_ready = 1'b1;
        cyc = 0;
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 10; i++) cycle();

        // Single request.
        do_reset();
        pv[0] = 1; pa[0] = 1; pb[0] = 5;
        for (int i = 0; i < 4; i++) cycle();
        check_val("t2_sum", 32'(q_at(got_sum, 0)), 6);
        check_val("t2_id", 32'(q_at(got_id, 0)), 0);

        // All four requesters, then requester 0 again.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin pv[i] = 1; pa[i] = i + 1; pb[i] = 3; end
        for (int i = 0; i < 12; i++) cycle();
        pv[0] = 1; pa[0] = 1; pb[0] = 3;
        for (int i = 0; i < 3; i++) cycle();
        check_val("t3_count", 32'(got_sum.size()), 5);
        for (int i = 0; i < 5; i++) begin
            check_val("t3_id", 32'(q_at(got_id, i)), (i == 4) ? 0 : i);
            check_val("t3_sum", 32'(q_at(got_sum, i)), (i == 4) ? 4 : i + 4);
        end
        for (int i = 1; i < 5; i++)
            check_val("t3_spacing", 32'(q_at(got_cyc, i) - q_at(got_cyc, i - 1)), 3);
`ifdef ADD_ARB_STATS_EN
        check_val("t3_grant_cnt", grant_cnt, {8'd1, 8'd1, 8'd1, 8'd2});
`endif

        // Max operands, no truncation.
        do_reset();
        pv[2] = 1; pa[2] = 15; pb[2] = 15;
        for (int i = 0; i < 4; i++) cycle();
        check_val("t4_sum", 32'(q_at(got_sum, 0)), 30);
        check_val("t4_id", 32'(q_at(got_id, 0)), 2);

        // Backpressure with another requester waiting.
        do_reset();
        rsp_ready = 1'b0;
        pv[1] = 1; pa[1] = 3; pb[1] = 4;
        cycle();
        pv[3] = 1; pa[3] = 2; pb[3] = 2;
        for (int i = 0; i < 6; i++) cycle();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check_val("t5_id0", 32'(q_at(got_id, 0)), 1);
        check_val("t5_sum0", 32'(q_at(got_sum, 0)), 7);
        check_val("t5_id1", 32'(q_at(got_id, 1)), 3);
        check_val("t5_sum1", 32'(q_at(got_sum, 1)), 4);
        check_val("t5_spacing", 32'(q_at(got_cyc, 1) - q_at(got_cyc, 0)), 3);

        // Reset during CALC discards the op.
        do_reset();
        pv[2] = 1; pa[2] = 9; pb[2] = 9;
        cycle();
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        check_val("t6_no_rsp", 32'(got_sum.size()), 0);
        pv[0] = 1; pa[0] = 2; pb[0] = 7;
        pv[1] = 1; pa[1] = 1; pb[1] = 1;
        for (int i = 0; i < 4; i++) cycle();
        check_val("t6_first_id", 32'(q_at(got_id, 0)), 0);
        check_val("t6_first_sum", 32'(q_at(got_sum, 0)), 9);

        // Randomized traffic with random backpressure and dropped requests.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pv[i] = 1;
                        pa[i] = int'($urandom_range(0, 15));
                        pb[i] = int'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pv[i] = 0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
